multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: MultiCycleController

---
 rtl/multi_cycle_controller_pkg.sv | 77 +++++++
 rtl/multi_cycle_controller_cond_check.sv | 37 +++
 rtl/multi_cycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle controller: state codes, ALU
// control encodings, instruction op/cmd fields and condition codes.
package multi_cycle_controller_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_e;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Control word produced by the state decode before reset gating.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_ctl;
  } ctrl_t;

  // Data-processing cmd to ALU control; CMP is a subtract, unknown cmds add.
  function automatic alu_ctl_e decode_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: decode_cmd = ALU_ADD;
      CMD_SUB: decode_cmd = ALU_SUB;
      CMD_AND: decode_cmd = ALU_AND;
      CMD_ORR: decode_cmd = ALU_ORR;
      CMD_CMP: decode_cmd = ALU_SUB;
      default: decode_cmd = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_cond_check.sv
// Condition evaluation: instruction cond field against the stored NZCV flags.
module multi_cycle_controller_cond_check
  import multi_cycle_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  // Pure combinational lookup; cond=1111 never executes.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore-style multi-cycle instruction controller with an internal NZCV
// register. Write enables are gated by the condition check and by reset.
//
// state      | meaning
// -----------+---------------------------------------------------------
// FETCH      | read instr at PC, load IR, PC <= PC+4
// DECODE     | read registers, ALU forms PC+8 for R15 reads
// MEMADR     | ALU computes base + offset for load/store
// MEMREAD    | read data memory at computed address
// MEMWB      | write loaded data to rd
// MEMWRITE   | write RD2 to data memory
// EXECR      | ALU op with register operand B
// EXECI      | ALU op with immediate operand B
// ALUWB      | write ALU result to rd (not for CMP)
// BRANCH     | PC <= PC+8 + offset when condition holds
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        adr_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic [2:0]  reg_src,
  output logic [1:0]  alu_ctl
);

  state_t     state;
  state_t     state_next;
  logic [3:0] flags;
  logic       cond_ex;
  ctrl_t      ctrl;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       is_cmp;
  logic       s_bit;
  logic       rd_is_pc;
  logic       in_exec;
  logic       flag_load;
  logic       unused_instr_bits;

  assign cond     = instr[31:28];
  assign op       = instr[27:26];
  assign funct    = instr[25:20];
  assign rd       = instr[15:12];
  assign cmd      = funct[4:1];
  assign is_cmp   = (cmd == CMD_CMP);
  assign s_bit    = funct[0] | is_cmp;
  assign rd_is_pc = (rd == 4'b1111);
  assign in_exec  = (state == S_EXECR) || (state == S_EXECI);

  // Register-number fields are consumed by the datapath, not the controller.
  assign unused_instr_bits = ^{instr[19:16], instr[11:0]};

  multi_cycle_controller_cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection from the current instruction fields.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_DP:   state_next = funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_next = S_MEMADR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Flags load at the end of an execute cycle for executed flag-setting ops;
  // logical ops (alu_ctl[1]=1) leave C and V untouched.
  assign flag_load = in_exec & cond_ex & s_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (flag_load) begin
      flags[3:2] <= alu_flags[3:2];
      if (!alu_ctl[1]) begin
        flags[1:0] <= alu_flags[1:0];
      end
    end
  end

  // Per-state control decode; anything not set for a state stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      S_MEMADR: begin
        ctrl.alu_src_b  = 2'b01;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = cond_ex;
      end
      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = cond_ex;
        ctrl.pc_write   = cond_ex & rd_is_pc;
      end
      S_EXECR: begin
        ctrl.alu_src_b  = 2'b00;
        ctrl.alu_ctl    = decode_cmd(cmd);
      end
      S_EXECI: begin
        ctrl.alu_src_b  = 2'b01;
        ctrl.alu_ctl    = decode_cmd(cmd);
      end
      S_ALUWB: begin
        ctrl.reg_write  = cond_ex & ~is_cmp;
        ctrl.pc_write   = cond_ex & ~is_cmp & rd_is_pc;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b01;
        ctrl.result_src = 2'b10;
        ctrl.pc_write   = cond_ex;
      end
      default: ctrl = '0;
    endcase
  end

  // Enables are masked combinationally so reset kills an in-flight write at once.
  assign pc_write   = ctrl.pc_write  & ~reset;
  assign ir_write   = ctrl.ir_write  & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign mem_write  = ctrl.mem_write & ~reset;
  assign adr_src    = ctrl.adr_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign alu_ctl    = ctrl.alu_ctl;
  assign imm_src    = op;
  assign reg_src    = {1'b0, (op == OP_MEM) & ~funct[0], (op == OP_BR)};

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: instruction-level model plus directed vectors.
module tb_multi_cycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        pc_write, ir_write, reg_write, mem_write;
  logic        adr_src, alu_src_a;
  logic [1:0]  alu_src_b, result_src, imm_src, alu_ctl;
  logic [2:0]  reg_src;

  int n_checks = 0;
  int n_fail   = 0;

  multi_cycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .alu_flags  (alu_flags),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .reg_src    (reg_src),
    .alu_ctl    (alu_ctl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef enum int {P_F, P_D, P_MA, P_MR, P_MW, P_MWR, P_XR, P_XI, P_AW, P_BR} phase_e;

  int         m_step  = 0;
  logic [3:0] m_flags = 4'b0000;

  function automatic int cpi_of(input logic [31:0] i);
    case (i[27:26])
      2'b00:   return 4;
      2'b01:   return i[20] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic phase_e phase_at(input logic [31:0] i, input int s);
    if (s == 0) return P_F;
    if (s == 1) return P_D;
    case (i[27:26])
      2'b00:   return (s == 2) ? (i[25] ? P_XI : P_XR) : P_AW;
      2'b01: begin
        if (s == 2) return P_MA;
        if (!i[20]) return P_MWR;
        return (s == 3) ? P_MR : P_MW;
      end
      2'b10:   return P_BR;
      default: return P_F;
    endcase
  endfunction

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'd0;
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
      4'b1010: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin : compare_proc
    phase_e     p;
    logic       ok, is_cmp;
    logic [3:0] cmd;
    logic       e_pw, e_iw, e_rw, e_mw, e_adr, e_a;
    logic [1:0] e_b, e_rs, e_ctl;
    p      = reset ? P_F : phase_at(instr, m_step);
    ok     = cond_holds(instr[31:28], m_flags);
    cmd    = instr[24:21];
    is_cmp = (cmd == 4'b1010);
    {e_pw, e_iw, e_rw, e_mw, e_adr, e_a} = 6'b0;
    {e_b, e_rs, e_ctl} = 6'b0;
    case (p)
      P_F:   begin e_iw = 1; e_pw = 1; e_a = 1; e_b = 2; e_rs = 2; end
      P_D:   begin e_a = 1; e_b = 2; e_rs = 2; end
      P_MA:  e_b = 1;
      P_MR:  e_adr = 1;
      P_MWR: begin e_adr = 1; e_mw = ok; end
      P_MW:  begin e_rs = 1; e_rw = ok; end
      P_XR:  e_ctl = alu_code(cmd);
      P_XI:  begin e_b = 1; e_ctl = alu_code(cmd); end
      P_AW:  e_rw = ok && !is_cmp;
      P_BR:  begin e_a = 1; e_b = 1; e_rs = 2; e_pw = ok; end
      default: ;
    endcase
    if ((p == P_MW || p == P_AW) && instr[15:12] == 4'hF) e_pw = e_rw;
    if (reset) {e_pw, e_iw, e_rw, e_mw} = 4'b0;

    check("pc_write",   pc_write,   e_pw);
    check("ir_write",   ir_write,   e_iw);
    check("reg_write",  reg_write,  e_rw);
    check("mem_write",  mem_write,  e_mw);
    check("adr_src",    adr_src,    e_adr);
    check("alu_src_a",  alu_src_a,  e_a);
    check("alu_src_b",  alu_src_b,  e_b);
    check("result_src", result_src, e_rs);
    check("alu_ctl",    alu_ctl,    e_ctl);
    check("imm_src",    imm_src,    instr[27:26]);
    check("reg_src",    reg_src,    {1'b0, instr[27:26] == 2'b01 && !instr[20], instr[27:26] == 2'b10});

    if (reset) begin
      m_step  = 0;
      m_flags = 4'b0000;
    end else begin
      if ((p == P_XR || p == P_XI) && ok && (instr[20] || is_cmp)) begin
        m_flags[3:2] = alu_flags[3:2];
        if (alu_code(cmd) < 2) m_flags[1:0] = alu_flags[1:0];
      end
      m_step = (m_step + 1 == cpi_of(instr)) ? 0 : m_step + 1;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] rw, pw, mw, iw;
  logic [1:0] rsl;
  logic [2:0] rgl;

  // Hold one instruction for n cycles, recording enables per cycle (bit k = cycle k).
  task automatic run(input logic [31:0] i, input logic [3:0] f, input int n,
                     output logic [7:0] o_rw, output logic [7:0] o_pw,
                     output logic [7:0] o_mw, output logic [7:0] o_iw,
                     output logic [1:0] o_rs, output logic [2:0] o_rg);
    instr = i;
    alu_flags = f;
    o_rw = '0; o_pw = '0; o_mw = '0; o_iw = '0; o_rs = '0; o_rg = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      o_rw[k] = reg_write;
      o_pw[k] = pc_write;
      o_mw[k] = mem_write;
      o_iw[k] = ir_write;
      o_rs    = result_src;
      o_rg    = reg_src;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'hE0812003;
    alu_flags = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ir_write", ir_write, 1'b0);
    check("rst_pc_write", pc_write, 1'b0);
    check("rst_alu_src_b", alu_src_b, 2'b10);
    reset = 1'b0;

    run(32'hE0812003, 4'b0000, 4, rw, pw, mw, iw, rsl, rgl);
    check("add_reg_write_seq", rw, 8'b0000_1000);
    check("add_ir_write_seq",  iw, 8'b0000_0001);

    run(32'hE5912004, 4'b0000, 5, rw, pw, mw, iw, rsl, rgl);
    check("ldr_ir_write_seq",  iw, 8'b0000_0001);
    check("ldr_reg_write_seq", rw, 8'b0001_0000);
    check("ldr_wb_result_src", rsl, 2'b01);

    run(32'hE5812004, 4'b0000, 4, rw, pw, mw, iw, rsl, rgl);
    check("str_mem_write_seq", mw, 8'b0000_1000);
    check("str_reg_src", rgl, 3'b010);
    check("str_reg_write_seq", rw, 8'b0000_0000);

    run(32'hE1510002, 4'b0100, 4, rw, pw, mw, iw, rsl, rgl);
    check("cmp_reg_write_seq", rw, 8'b0000_0000);
    run(32'h0A000002, 4'b0000, 3, rw, pw, mw, iw, rsl, rgl);
    check("beq_taken_pc_write", pw, 8'b0000_0101);
    run(32'h1A000002, 4'b0000, 3, rw, pw, mw, iw, rsl, rgl);
    check("bne_not_taken_pc_write", pw, 8'b0000_0001);

    run(32'hE0912003, 4'b1000, 4, rw, pw, mw, iw, rsl, rgl);
    check("adds_reg_write_seq", rw, 8'b0000_1000);
    run(32'h4A000002, 4'b0000, 3, rw, pw, mw, iw, rsl, rgl);
    check("bmi_after_adds", pw, 8'b0000_0101);
    run(32'h0A000002, 4'b0000, 3, rw, pw, mw, iw, rsl, rgl);
    check("beq_after_adds", pw, 8'b0000_0001);

    run(32'hE0112003, 4'b0111, 4, rw, pw, mw, iw, rsl, rgl);
    run(32'h0A000002, 4'b0000, 3, rw, pw, mw, iw, rsl, rgl);
    check("beq_after_ands", pw, 8'b0000_0101);
    run(32'h2A000002, 4'b0000, 3, rw, pw, mw, iw, rsl, rgl);
    check("bcs_c_held", pw, 8'b0000_0001);
    run(32'h6A000002, 4'b0000, 3, rw, pw, mw, iw, rsl, rgl);
    check("bvs_v_held", pw, 8'b0000_0001);

    run(32'h10812003, 4'b0000, 4, rw, pw, mw, iw, rsl, rgl);
    check("addne_skipped", rw, 8'b0000_0000);
    run(32'hE3812003, 4'b0000, 4, rw, pw, mw, iw, rsl, rgl);
    check("orr_imm_reg_write", rw, 8'b0000_1000);
    run(32'hE0412003, 4'b0000, 4, rw, pw, mw, iw, rsl, rgl);
    run(32'hE081F003, 4'b0000, 4, rw, pw, mw, iw, rsl, rgl);
    check("add_rd15_pc_write", pw, 8'b0000_1001);

    // Abort a store in MEMWRITE.
    instr = 32'hE5812004;
    alu_flags = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("memwrite_before_reset", mem_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("memwrite_drops", mem_write, 1'b0);
    check("reset_pc_write", pc_write, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    run(32'hEC000000, 4'b0000, 2, rw, pw, mw, iw, rsl, rgl);
    check("undef_ir_write_seq", iw, 8'b0000_0001);
    check("undef_reg_write", rw, 8'b0000_0000);
    check("undef_mem_write", mw, 8'b0000_0000);
    run(32'hEC000000, 4'b0000, 2, rw, pw, mw, iw, rsl, rgl);
    check("undef_returns_fetch", iw, 8'b0000_0001);
    run(32'h0A000002, 4'b0000, 3, rw, pw, mw, iw, rsl, rgl);
    check("flags_cleared_by_reset", pw, 8'b0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
